pixel_hierarchy_arbiter: RTL and testbench
==========================================

Name: pixel_hierarchy_arbiter

Overview:
Hierarchical round-robin event arbiter for a 16x16 event-camera pixel array.
- Level 0: pixels, each carrying a 2-bit polarity request.
- Level 1: sixteen 4x4 pixel groups.
- Level 2: top arbiter choosing among the groups.

Each cycle at most one pixel is granted. The block emits a one-hot grant back to the array and an event word {row, col, polarity} to the readout path.

Parameters:
- Lvl0_PIXELS, 16, array side length (rows = cols).
- POLARITY, 2, request bits per pixel: 01 = ON event, 10 = OFF event, 00 = idle.
- GRP_SIZE, 4, group side length (16 pixels per group).
- WIDTH, 10, event word width: 4-bit row + 4-bit col + POLARITY.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- set_i  in  [16][16][POLARITY]  per-pixel request/polarity; set_i[row][col].
- gnt_o  out  [16][16]  one-hot pixel grant, registered.
- grp_release_2  out  1  registered pulse: the issued grant emptied its group.
- data_out_o  out  WIDTH  registered event word {row[3:0], col[3:0], pol[1:0]}.

Behaviour:
- Reset (reset_i low at posedge): gnt_o=0, data_out_o=0, grp_release_2=0, lock cleared, top pointer=group 0, all group pointers=local 0, mask cleared.
- Indexing:
  - group g = (row/4)*4 + col/4;
  - local index l = (row%4)*4 + col%4;
  - row = (g/4)*4 + l/4, col = (g%4)*4 + l%4.
- Pixel eligible: set_i != 0 and the pixel was not granted in the previous cycle (1-cycle grant mask).
- Requester contract: drop the request on the edge where it samples its gnt_o bit.
- Code 11 is treated as a request; its polarity bits pass through unchanged.
- Group arbitration, per cycle:
  - If a group is locked and has an eligible pixel, grant within it.
  - Otherwise pick the next group with an eligible pixel, round-robin starting at (last granted group + 1) mod 16, and lock it.
- Within-group arbitration: round-robin over local index, starting at (that group's last granted local index + 1) mod 16. Each group keeps its own pointer.
- Grant register: on a grant, exactly one gnt_o bit is high for exactly one cycle, and data_out_o carries that pixel's row, col and set_i value sampled at the deciding edge.
- Latency: the request is seen at edge k; gnt_o and data_out_o are valid after edge k.
- No eligible pixel anywhere: gnt_o=0, data_out_o=0, grp_release_2=0; pointers and lock are unchanged.
- grp_release_2: high in the same cycle as the grant when no other eligible pixel remains in that group at the deciding edge. The lock then clears and the next decision rotates groups.
- A locked group keeps the lock while it has eligible pixels, including requests that arrive during the lock.
- Simultaneous requests in different groups: only the locked or round-robin-selected group is served; the others wait.
- Reset mid-operation: in-flight grant dropped and outputs zeroed on the next edge; pending requests are re-arbitrated from group 0 after release.

Decomposition:
- lib_arbiter_pkg holds Lvl0_PIXELS, POLARITY, WIDTH, GRP_SIZE, NUM_GROUPS=16, and the polarity code constants.
- One sub-module, rr_arbiter16: 16-request round-robin arbiter with pointer input and one-hot/index output. It is instanced once for the top level and once, muxed by the selected group, for the local level.

Test Plan:
- Reset: hold reset_i=0 for 2 cycles with random set_i -> gnt_o=0, data_out_o=0, grp_release_2=0.
- Single event: set_i[5][9]=01 -> next cycle gnt_o[5][9]=1, data_out_o={4'd5,4'd9,2'b01}, grp_release_2=1. Once the request drops, idle with all outputs 0.
- Same-group drain:
  - Stimulus: set_i[0][0]=01, [0][1]=10, [1][0]=01.
  - Response: grants in consecutive cycles in the order (0,0), (0,1), (1,0).
  - grp_release_2 high only with the (1,0) grant.
- Cross-group round-robin:
  - Stimulus: pixels (0,0) in g0 and (4,4) in g5 set together.
  - Response: (0,0) granted first with release. Next cycle (4,4) granted with release.
  - Re-request in both -> g5 has priority after g0... no: after g5, g0 is next.
- Lock hold: while g0 is locked, add request (2,2) before the drain ends -> (2,2) served before any other group; release on the last g0 grant.
- Random fill: all 256 pixels get values 0..2 with the handshake -> every nonzero pixel granted exactly once. Never more than one gnt_o bit high. Every data_out_o matches the grant index and polarity.

Source files
------------

// File: rtl/lib_arbiter_pkg.sv
// Shared parameters, polarity codes and pixel index helpers for the pixel hierarchy arbiter.
package lib_arbiter_pkg;
   localparam int unsigned Lvl0_PIXELS = 16;
   localparam int unsigned POLARITY    = 2;
   localparam int unsigned GRP_SIZE    = 4;
   localparam int unsigned NUM_GROUPS  = 16;
   localparam int unsigned WIDTH       = 10;

   typedef enum logic [POLARITY-1:0] {
      POL_IDLE = 2'b00,
      POL_ON   = 2'b01,
      POL_OFF  = 2'b10,
      POL_BOTH = 2'b11
   } pol_e;

   typedef enum logic {
      ST_ROTATE,
      ST_LOCKED
   } lock_e;

   // Group g / local index l back to array coordinates (4x4 groups of 4x4 pixels).
   function automatic logic [3:0] pix_row(input logic [3:0] g, input logic [3:0] l);
      return {g[3:2], l[3:2]};
   endfunction

   function automatic logic [3:0] pix_col(input logic [3:0] g, input logic [3:0] l);
      return {g[1:0], l[1:0]};
   endfunction
endpackage

// File: rtl/pixel_hierarchy_arbiter_if.sv
// Request/grant/event bundle between the pixel array, the arbiter and the readout path.
interface pixel_hierarchy_arbiter_if;
   import lib_arbiter_pkg::*;

   logic [Lvl0_PIXELS-1:0][Lvl0_PIXELS-1:0][POLARITY-1:0] set_i;
   logic [Lvl0_PIXELS-1:0][Lvl0_PIXELS-1:0]               gnt_o;
   logic                                                  grp_release_2;
   logic [WIDTH-1:0]                                      data_out_o;

   modport master (
      output set_i,
      input  gnt_o,
      input  grp_release_2,
      input  data_out_o
   );

   modport slave (
      input  set_i,
      output gnt_o,
      output grp_release_2,
      output data_out_o
   );
endinterface

// File: rtl/pixel_hierarchy_arbiter_rr.sv
// 16-way round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter16 (
   input  logic [15:0] req_i,
   input  logic [3:0]  ptr_i,
   output logic [15:0] gnt_o,
   output logic [3:0]  idx_o
);
   logic [3:0] cand;
   logic       found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         cand = ptr_i + 4'(i);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end
endmodule

// File: rtl/pixel_hierarchy_arbiter.sv
// Two-level round-robin event arbiter: group pick (with lock until the group drains),
// then a per-group local pick; one registered pixel grant and event word per cycle.
module pixel_hierarchy_arbiter
   import lib_arbiter_pkg::*;
(
   input logic                       clk_i,
   input logic                       reset_i,
   pixel_hierarchy_arbiter_if.slave  bus
);
   logic [Lvl0_PIXELS-1:0][Lvl0_PIXELS-1:0] gnt_q, gnt_d;
   logic [WIDTH-1:0]                        data_q, data_d;
   logic                                    rel_q, rel_d;
   lock_e                                   lock_q, lock_d;
   logic [3:0]                              top_ptr_q, top_ptr_d;
   logic [NUM_GROUPS-1:0][3:0]              grp_ptr_q, grp_ptr_d;

   logic [NUM_GROUPS-1:0][15:0] elig;
   logic [NUM_GROUPS-1:0]       grp_any;
   logic [15:0]                 top_oh, loc_oh;
   logic [3:0]                  top_idx, loc_idx;
   logic [3:0]                  lock_grp, sel_grp, sel_row, sel_col;
   logic                        lock_hit, any_req, grp_done;

   // A pixel granted last cycle is masked so its still-high request is not re-served.
   always_comb begin
      elig    = '0;
      grp_any = '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
         for (int unsigned l = 0; l < NUM_GROUPS; l++) begin
            elig[g][l] = (bus.set_i[pix_row(4'(g), 4'(l))][pix_col(4'(g), 4'(l))] != POL_IDLE)
                         && !gnt_q[pix_row(4'(g), 4'(l))][pix_col(4'(g), 4'(l))];
         end
         grp_any[g] = |elig[g];
      end
   end

   rr_arbiter16 u_top_arb (
      .req_i (grp_any),
      .ptr_i (top_ptr_q),
      .gnt_o (top_oh),
      .idx_o (top_idx)
   );

   // top_ptr_q always points one past the last granted group, which is the locked one.
   assign lock_grp = top_ptr_q - 4'd1;
   assign lock_hit = (lock_q == ST_LOCKED) && grp_any[lock_grp];
   assign sel_grp  = lock_hit ? lock_grp : top_idx;
   assign any_req  = |top_oh;

   rr_arbiter16 u_loc_arb (
      .req_i (elig[sel_grp]),
      .ptr_i (grp_ptr_q[sel_grp]),
      .gnt_o (loc_oh),
      .idx_o (loc_idx)
   );

   assign grp_done = ((elig[sel_grp] & ~loc_oh) == '0);
   assign sel_row  = pix_row(sel_grp, loc_idx);
   assign sel_col  = pix_col(sel_grp, loc_idx);

   always_comb begin
      gnt_d     = '0;
      data_d    = '0;
      rel_d     = 1'b0;
      lock_d    = lock_q;
      top_ptr_d = top_ptr_q;
      grp_ptr_d = grp_ptr_q;
      if (any_req) begin
         gnt_d[sel_row][sel_col] = 1'b1;
         data_d                  = {sel_row, sel_col, bus.set_i[sel_row][sel_col]};
         rel_d                   = grp_done;
         lock_d                  = grp_done ? ST_ROTATE : ST_LOCKED;
         top_ptr_d               = sel_grp + 4'd1;
         grp_ptr_d[sel_grp]      = loc_idx + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         gnt_q     <= '0;
         data_q    <= '0;
         rel_q     <= 1'b0;
         lock_q    <= ST_ROTATE;
         top_ptr_q <= '0;
         grp_ptr_q <= '0;
      end else begin
         gnt_q     <= gnt_d;
         data_q    <= data_d;
         rel_q     <= rel_d;
         lock_q    <= lock_d;
         top_ptr_q <= top_ptr_d;
         grp_ptr_q <= grp_ptr_d;
      end
   end

   assign bus.gnt_o         = gnt_q;
   assign bus.data_out_o    = data_q;
   assign bus.grp_release_2 = rel_q;
endmodule

// File: tb/tb_pixel_hierarchy_arbiter.sv
// Bench for pixel_hierarchy_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-free behavioural model.
module tb_pixel_hierarchy_arbiter;
   import lib_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset_i = 1'b0;
   always #5 clk = ~clk;

   pixel_hierarchy_arbiter_if bus ();

   pixel_hierarchy_arbiter dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [255:0] exp_gnt = '0;
   logic [9:0]   exp_data = '0;
   logic         exp_rel = 1'b0;
   bit           model_valid = 1'b0;

   int m_start = 0;
   int m_lock_grp = 0;
   bit m_locked = 1'b0;
   int m_loc_start[16];
   int m_prev_r = -1;
   int m_prev_c = -1;
   int gcount[256];
   logic [1:0] init_val[256];

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [255:0] onehot(input int r, input int c);
      logic [255:0] v;
      v = '0;
      v[r*16+c] = 1'b1;
      return v;
   endfunction

   function automatic bit m_elig(input int r, input int c);
      return (bus.set_i[r][c] != 2'b00) && !(r == m_prev_r && c == m_prev_c);
   endfunction

   // Behavioural reference: decides from the rules directly each rising edge.
   always @(posedge clk) begin : model
      int gcnt[16];
      int g, r, c, l, pick_l;
      model_valid = 1'b1;
      if (!reset_i) begin
         exp_gnt = '0; exp_data = '0; exp_rel = 1'b0;
         m_start = 0; m_locked = 1'b0; m_lock_grp = 0;
         for (int i = 0; i < 16; i++) m_loc_start[i] = 0;
         m_prev_r = -1; m_prev_c = -1;
      end else begin
         for (int i = 0; i < 16; i++) gcnt[i] = 0;
         for (int rr = 0; rr < 16; rr++)
            for (int cc = 0; cc < 16; cc++)
               if (m_elig(rr, cc)) gcnt[(rr/4)*4 + cc/4]++;
         g = -1;
         if (m_locked && gcnt[m_lock_grp] > 0) g = m_lock_grp;
         else
            for (int k = 0; k < 16; k++)
               if (g < 0 && gcnt[(m_start + k) % 16] > 0) g = (m_start + k) % 16;
         if (g < 0) begin
            exp_gnt = '0; exp_data = '0; exp_rel = 1'b0;
            m_prev_r = -1; m_prev_c = -1;
         end else begin
            pick_l = -1;
            for (int k = 0; k < 16; k++) begin
               l = (m_loc_start[g] + k) % 16;
               if (pick_l < 0 && m_elig((g/4)*4 + l/4, (g%4)*4 + l%4)) pick_l = l;
            end
            r = (g/4)*4 + pick_l/4;
            c = (g%4)*4 + pick_l%4;
            exp_gnt  = onehot(r, c);
            exp_data = {4'(r), 4'(c), bus.set_i[r][c]};
            exp_rel  = (gcnt[g] == 1);
            m_locked = (gcnt[g] != 1);
            m_lock_grp = g;
            m_start = (g + 1) % 16;
            m_loc_start[g] = (pick_l + 1) % 16;
            m_prev_r = r; m_prev_c = c;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("cyc_gnt", bus.gnt_o, exp_gnt);
         chk("cyc_data", 256'(bus.data_out_o), 256'(exp_data));
         chk("cyc_rel", 256'(bus.grp_release_2), 256'(exp_rel));
         chk("cyc_onehot", 256'($countones(bus.gnt_o) <= 1), 256'(1));
      end
   end

   // One clock; the requester drops a request once it sees its grant.
   task automatic step();
      @(posedge clk);
      #1;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            if (bus.gnt_o[r][c]) begin
               bus.set_i[r][c] = 2'b00;
               gcount[r*16+c]++;
            end
   endtask

   task automatic start_case();
      bus.set_i = '0;
      reset_i = 1'b0;
      step();
      reset_i = 1'b1;
   endtask

   task automatic expect_grant(input string name, input int r, input int c,
                               input logic [1:0] pol, input logic rel);
      step();
      chk({name, "_gnt"}, bus.gnt_o, onehot(r, c));
      chk({name, "_data"}, 256'(bus.data_out_o), 256'({4'(r), 4'(c), pol}));
      chk({name, "_rel"}, 256'(bus.grp_release_2), 256'(rel));
   endtask

   task automatic expect_idle(input string name);
      step();
      chk({name, "_gnt"}, bus.gnt_o, '0);
      chk({name, "_data"}, 256'(bus.data_out_o), '0);
      chk({name, "_rel"}, 256'(bus.grp_release_2), '0);
   endtask

   initial begin
      bit left;
      bus.set_i = '0;
      for (int i = 0; i < 256; i++) gcount[i] = 0;

      // Reset with random requests present.
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) bus.set_i[r][c] = 2'($urandom_range(0, 3));
      reset_i = 1'b0;
      expect_idle("reset1");
      expect_idle("reset2");

      start_case();
      bus.set_i[5][9] = 2'b01;
      expect_grant("single", 5, 9, 2'b01, 1'b1);
      chk("single_word", 256'(bus.data_out_o), 256'(10'b0101_1001_01));
      expect_idle("single_idle");

      start_case();
      bus.set_i[0][0] = 2'b01; bus.set_i[0][1] = 2'b10; bus.set_i[1][0] = 2'b01;
      expect_grant("drain_a", 0, 0, 2'b01, 1'b0);
      expect_grant("drain_b", 0, 1, 2'b10, 1'b0);
      expect_grant("drain_c", 1, 0, 2'b01, 1'b1);

      start_case();
      bus.set_i[0][0] = 2'b01; bus.set_i[4][4] = 2'b10;
      expect_grant("cross_a", 0, 0, 2'b01, 1'b1);
      expect_grant("cross_b", 4, 4, 2'b10, 1'b1);
      bus.set_i[0][0] = 2'b01; bus.set_i[4][4] = 2'b10;
      expect_grant("cross_c", 0, 0, 2'b01, 1'b1);
      expect_grant("cross_d", 4, 4, 2'b10, 1'b1);

      start_case();
      bus.set_i[0][0] = 2'b01; bus.set_i[0][1] = 2'b01; bus.set_i[4][4] = 2'b11;
      expect_grant("lock_a", 0, 0, 2'b01, 1'b0);
      bus.set_i[2][2] = 2'b10;
      expect_grant("lock_b", 0, 1, 2'b01, 1'b0);
      expect_grant("lock_c", 2, 2, 2'b10, 1'b1);
      expect_grant("lock_d", 4, 4, 2'b11, 1'b1);

      // Random fill: every nonzero pixel must be granted exactly once.
      start_case();
      for (int i = 0; i < 256; i++) begin
         gcount[i] = 0;
         init_val[i] = 2'($urandom_range(0, 2));
         bus.set_i[i/16][i%16] = init_val[i];
      end
      left = 1'b1;
      for (int cyc = 0; cyc < 600 && left; cyc++) begin
         step();
         left = (bus.set_i != '0);
      end
      chk("fill_drained", 256'(left), '0);
      for (int i = 0; i < 256; i++)
         chk("fill_once", 256'(gcount[i]), 256'(init_val[i] != 2'b00));

      // Random traffic with a mid-run reset.
      start_case();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 2) == 0)
            for (int k = 0; k < 3; k++)
               bus.set_i[$urandom_range(0, 15)][$urandom_range(0, 15)] = 2'($urandom_range(0, 3));
         if (cyc == 200) reset_i = 1'b0;
         step();
         reset_i = 1'b1;
      end

      bus.set_i = '0;
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
